// File: rtl/sha_256_pkg.sv
// Shared types, constants and bit-mixing functions for the single-block SHA-256 engine.
// Round constants and the initial hash value are the FIPS 180-4 values.
package sha_256_pkg;

  localparam int MSG_SIZ   = 512;
  localparam int MSG_BLK   = 32;
  localparam int MAX_CNT   = 63;
  localparam int HASH_SIZE = 256;
  localparam int NUM_W     = MSG_SIZ / MSG_BLK;
  localparam int CNT_W     = 6;

  typedef logic [MSG_BLK-1:0] word_t;

  // Packed so that 'a' lands in the top word, matching the digest layout.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  localparam work_t H0 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (MSG_BLK - n));
  endfunction

  function automatic word_t S0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t S1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t s0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t s1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t Ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t Maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise mod 2^32 sum; carries must not ripple across word boundaries.
  function automatic work_t addState(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha_256_round.sv
// One SHA-256 compression round, purely combinational.
module sha_256_round
  import sha_256_pkg::*;
(
  input  work_t state_i,
  input  word_t w_i,
  input  word_t k_i,
  output work_t state_o
);

  word_t t1;
  word_t t2;

  assign t1 = state_i.h + S1(state_i.e) + Ch(state_i.e, state_i.f, state_i.g) + k_i + w_i;
  assign t2 = S0(state_i.a) + Maj(state_i.a, state_i.b, state_i.c);

  assign state_o = {t1 + t2, state_i.a, state_i.b, state_i.c,
                    state_i.d + t1, state_i.e, state_i.f, state_i.g};

endmodule

// File: rtl/sha_256.sv
// Single-block SHA-256 engine: captures a padded 512-bit block, runs 64 rounds
// (one per clock) and publishes H0 + compressed state with a one-cycle valid pulse.
module sha_256
  import sha_256_pkg::*;
(
  input  logic                 usr_clk,
  input  logic                 usr_reset_n,
  input  logic                 i_start,
  input  logic [MSG_SIZ-1:0]   i_msg,
  output logic                 o_valid,
  output logic [HASH_SIZE-1:0] o_hash
);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  word_t                  win_q [NUM_W];
  word_t                  win_d [NUM_W];
  work_t                  work_q, work_d;
  work_t                  roundOut;
  word_t                  wNext;
  logic [HASH_SIZE-1:0]   hash_q, hash_d;
  logic                   valid_q, valid_d;

  sha_256_round u_round (
    .state_i (work_q),
    .w_i     (win_q[0]),
    .k_i     (K[cnt_q]),
    .state_o (roundOut)
  );

  // Window holds W[t..t+15]; the word entering at the tail is W[t+16].
  assign wNext = s1(win_q[14]) + win_q[9] + s0(win_q[1]) + win_q[0];

  always_ff @(posedge usr_clk or negedge usr_reset_n) begin
    if (!usr_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      win_q   <= '{default: '0};
      work_q  <= '0;
      hash_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      work_q  <= work_d;
      hash_q  <= hash_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    work_d  = work_q;
    hash_d  = hash_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          for (int i = 0; i < NUM_W; i++) begin
            win_d[i] = i_msg[MSG_SIZ-1-i*MSG_BLK -: MSG_BLK];
          end
          work_d  = H0;
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = roundOut;
        for (int i = 0; i < NUM_W - 1; i++) begin
          win_d[i] = win_q[i+1];
        end
        win_d[NUM_W-1] = wNext;
        if (cnt_q == CNT_W'(MAX_CNT)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        hash_d  = addState(H0, work_q);
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_valid = valid_q;
  assign o_hash  = hash_q;

endmodule

// File: tb/tb_sha_256.sv
// Directed and randomized checks of sha_256 against known digests and an
// array-based SHA-256 reference model.
module tb_sha_256;

  logic         usr_clk = 1'b0;
  logic         usr_reset_n;
  logic         i_start;
  logic [511:0] i_msg;
  logic         o_valid;
  logic [255:0] o_hash;

  int total = 0;
  int bad   = 0;

  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] H0REF [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  always #5 usr_clk = ~usr_clk;

  sha_256 dut (
    .usr_clk     (usr_clk),
    .usr_reset_n (usr_reset_n),
    .i_start     (i_start),
    .i_msg       (i_msg),
    .o_valid     (o_valid),
    .o_hash      (o_hash)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Full 64-entry message schedule computed up front, then the textbook round loop.
  function automatic logic [255:0] refDigest(input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2, sg0, sg1;
    logic [255:0] dig;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      sg0  = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      sg1  = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = sg1 + w[t-7] + sg0 + w[t-16];
    end
    v = H0REF;
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KREF[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) dig[255-32*i -: 32] = H0REF[i] + v[i];
    return dig;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [511:0] blk, input logic start);
    @(negedge usr_clk);
    i_msg   = blk;
    i_start = start;
  endtask

  // Returns number of negedges until o_valid is seen, or -1 if the budget runs out.
  task automatic waitValid(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge usr_clk);
      cycles++;
    end while (o_valid !== 1'b1 && cycles < budget);
    if (o_valid !== 1'b1) cycles = -1;
  endtask

  task automatic hashOnce(input logic [511:0] blk, output int lat);
    applyStimulus(blk, 1'b1);
    @(negedge usr_clk);
    i_start = 1'b0;
    waitValid(200, lat);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           n;
    logic [255:0] held;
    logic [511:0] blk;
    bit           glitch;

    usr_reset_n = 1'b0;
    i_start     = 1'b0;
    i_msg       = '0;
    repeat (5) @(negedge usr_clk);
    checkOutput("reset valid", 256'(o_valid), 256'd0);
    checkOutput("reset hash", o_hash, 256'd0);
    usr_reset_n = 1'b1;

    hashOnce(MSG_ABC, n);
    checkOutput("abc latency", 256'(n), 256'd65);
    checkOutput("abc digest", o_hash, DIG_ABC);
    checkOutput("abc model", o_hash, refDigest(MSG_ABC));
    @(negedge usr_clk);
    checkOutput("valid one cycle", 256'(o_valid), 256'd0);
    checkOutput("hash holds idle", o_hash, DIG_ABC);

    for (int k = 0; k < 4; k++) begin
      blk = randBlock();
      hashOnce(blk, n);
      checkOutput("random latency", 256'(n), 256'd65);
      checkOutput("random digest", o_hash, refDigest(blk));
    end

    applyStimulus(MSG_ABC, 1'b1);
    waitValid(200, n);
    checkOutput("b2b first latency", 256'(n), 256'd66);
    checkOutput("b2b first digest", o_hash, DIG_ABC);
    for (int p = 0; p < 2; p++) begin
      held   = o_hash;
      glitch = 1'b0;
      n      = 0;
      do begin
        @(negedge usr_clk);
        n++;
        if (o_valid !== 1'b1 && o_hash !== held) glitch = 1'b1;
      end while (o_valid !== 1'b1 && n < 200);
      checkOutput("b2b period", 256'(n), 256'd66);
      checkOutput("b2b digest", o_hash, DIG_ABC);
      checkOutput("b2b hash held", 256'(glitch), 256'd0);
    end
    i_start = 1'b0;
    @(negedge usr_clk);
    checkOutput("b2b valid drop", 256'(o_valid), 256'd0);

    hashOnce(MSG_EMPTY, n);
    checkOutput("empty latency", 256'(n), 256'd65);
    checkOutput("empty digest", o_hash, DIG_EMPTY);
    checkOutput("empty model", o_hash, refDigest(MSG_EMPTY));

    applyStimulus(MSG_ABC, 1'b1);
    @(negedge usr_clk);
    for (int c = 0; c < 20; c++) begin
      i_msg   = randBlock();
      i_start = ~i_start;
      @(negedge usr_clk);
    end
    i_start = 1'b0;
    waitValid(200, n);
    checkOutput("busy latency", 256'(n), 256'd45);
    checkOutput("busy digest", o_hash, DIG_ABC);

    applyStimulus(MSG_ABC, 1'b1);
    @(negedge usr_clk);
    i_start = 1'b0;
    repeat (29) @(negedge usr_clk);
    #2 usr_reset_n = 1'b0;
    #1;
    checkOutput("midreset valid", 256'(o_valid), 256'd0);
    checkOutput("midreset hash", o_hash, 256'd0);
    repeat (2) @(negedge usr_clk);
    checkOutput("midreset no output", o_hash, 256'd0);
    usr_reset_n = 1'b1;
    hashOnce(MSG_ABC, n);
    checkOutput("restart latency", 256'(n), 256'd65);
    checkOutput("restart digest", o_hash, DIG_ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
